// File: rtl/ofifo_pkg.sv
// Shared widths, count type and read-path clamp for the skewed-column output FIFO.
// The OFIFO_RELU_EN build option (see ofifo_skew) uses relu_clamp from here.
package ofifo_pkg;

    function automatic int PTR_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Wide enough for any supported DEPTH (up to 65536); per-block counts are narrowed.
    localparam int CNT_MAX_W = 17;
    typedef logic [CNT_MAX_W-1:0] col_cnt_t;

    // Callers sign-extend their slice to RELU_W bits and narrow the result.
    localparam int RELU_W = 64;

    function automatic logic signed [RELU_W-1:0] relu_clamp(input logic signed [RELU_W-1:0] v);
        return v[RELU_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// One column of the output FIFO: circular store, own write pointer and count.
// The read pointer and pop strobe are shared across all columns by the top level.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 64,
    localparam int PW     = PTR_W(DEPTH),
    localparam int CW     = CNT_W(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_wr,
    input  logic signed [PSUM_BW-1:0] i_din,
    input  logic                      i_pop,
    input  logic [PW-1:0]             i_rptr,
    output logic [CW-1:0]             o_cnt,
    output logic signed [PSUM_BW-1:0] o_head,
    output logic                      o_drop
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic signed [PSUM_BW-1:0] r_mem [DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [CW-1:0]             r_cnt;
    logic                      w_full;
    logic                      w_acc;

    // A full column still accepts a write when a pop frees the head slot in the same cycle.
    assign w_full = (r_cnt == FULL_CNT);
    assign w_acc  = i_wr && (!w_full || i_pop);
    assign o_drop = i_wr && w_full && !i_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_acc && !i_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_acc && i_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && !reset) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_mem[i_rptr];

endmodule

// File: rtl/ofifo_skew.sv
// Output FIFO absorbing per-column skew from the PE array; releases aligned rows.
// Define OFIFO_RELU_EN to clamp negative slices to zero on the read path.
module ofifo_skew
    import ofifo_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 64,
    localparam int PW     = PTR_W(DEPTH),
    localparam int CW     = CNT_W(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COL*PSUM_BW-1:0] in,
    input  logic [COL-1:0]         wr,
    input  logic                   rd,
    output logic [COL*PSUM_BW-1:0] out,
    output logic                   o_rd_vld,
    output logic                   o_valid,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow,
    output logic [CW-1:0]          o_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]             w_cnt  [COL];
    logic signed [PSUM_BW-1:0] w_head [COL];
    logic [COL-1:0]            w_drop;
    logic                      w_pop;
    logic                      w_valid;
    logic                      w_empty;
    logic                      w_full;
    col_cnt_t                  w_min;
    logic [COL*PSUM_BW-1:0]    w_row;

    logic [PW-1:0]             r_rptr;
    logic [COL*PSUM_BW-1:0]    r_out_p1;
    logic                      r_rd_vld_p1;
    logic                      r_ovf;

    assign w_pop = rd && w_valid;

    for (genvar c = 0; c < COL; c++) begin : g_col
        ofifo_col #(
            .PSUM_BW (PSUM_BW),
            .DEPTH   (DEPTH)
        ) u_col (
            .clk    (clk),
            .reset  (reset),
            .i_wr   (wr[c]),
            .i_din  (in[c*PSUM_BW +: PSUM_BW]),
            .i_pop  (w_pop),
            .i_rptr (r_rptr),
            .o_cnt  (w_cnt[c]),
            .o_head (w_head[c]),
            .o_drop (w_drop[c])
        );
    end

    always_comb begin
        w_valid = 1'b1;
        w_empty = 1'b1;
        w_full  = 1'b0;
        w_min   = col_cnt_t'(w_cnt[0]);
        for (int c = 0; c < COL; c++) begin
            w_valid = w_valid && (w_cnt[c] != '0);
            w_empty = w_empty && (w_cnt[c] == '0);
            w_full  = w_full  || (w_cnt[c] == FULL_CNT);
            if (col_cnt_t'(w_cnt[c]) < w_min) begin
                w_min = col_cnt_t'(w_cnt[c]);
            end
        end
    end

    always_comb begin
        w_row = '0;
        for (int c = 0; c < COL; c++) begin
`ifdef OFIFO_RELU_EN
            w_row[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(relu_clamp(RELU_W'(w_head[c])));
`else
            w_row[c*PSUM_BW +: PSUM_BW] = w_head[c];
`endif
        end
    end

    // Stage p1: registered output row, pop strobe and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr      <= '0;
            r_out_p1    <= '0;
            r_rd_vld_p1 <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_pop;
            if (w_pop) begin
                r_out_p1 <= w_row;
                r_rptr   <= r_rptr + 1'b1;
            end
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out        = r_out_p1;
    assign o_rd_vld   = r_rd_vld_p1;
    assign o_valid    = w_valid;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_ready    = !w_full;
    assign o_overflow = r_ovf;
    assign o_count    = w_min[CW-1:0];

endmodule
